ucsbece154b_branch_resolve: RTL
===============================

// Module: ucsbece154b_branch_resolve
// PURPOSE
//  Execute-side counterpart of the fetch branch predictor: carries each fetched instruction's
//  prediction (taken, target, BTB hit, PHT index) down F->D->E, resolves it in E, and
//  produces mispredict flush/redirect plus the BTB, PHT and GHR update strobes consumed by
//  ucsbece154b_branch. Also keeps saturating branch and mispredict counters for the lab report.
// PARAMETERS
//  NUM_BTB_ENTRIES  32  BTB depth; index = pc[$clog2(N)+1:2]
//  NUM_GHR_BITS     5   PHT index width (G)
//  CNT_W            16  width of performance counters
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  reset_i             in   1   asynchronous, active-low reset
//  pc_f_i              in   32  fetch PC
//  BranchTaken_f_i     in   1   predictor taken/jump prediction for pc_f_i
//  BTBtarget_f_i       in   32  predicted target for pc_f_i
//  BTBhit_f_i          in   1   BTB valid+tag match for pc_f_i
//  PHTreadaddress_f_i  in   G   PHT index used for pc_f_i
//  StallD_i            in   1   hold F->D register
//  FlushD_i            in   1   invalidate D
//  FlushE_i            in   1   invalidate E
//  op_e_i              in   7   opcode of instruction in E
//  taken_e_i           in   1   actual outcome in E (branch taken, or any jal/jalr)
//  target_e_i          in   32  actual target computed in E
//  cnt_clr_i           in   1   synchronous clear of both counters
//  Mispredict_o        out  1   comb., flush D/E and redirect fetch this cycle
//  PCredirect_o        out  32  comb., correct next PC when Mispredict_o
//  BTB_we_o            out  1   reg., BTB write strobe
//  BTBwriteaddress_o   out  log2(N)  reg., BTB index
//  BTBwritedata_o      out  32  reg., BTB target
//  PHTwe_o             out  1   reg., PHT update strobe
//  PHTincrement_o      out  1   reg., 1 = increment counter
//  PHTwriteaddress_o   out  G   reg., PHT index to update
//  GHRreset_o          out  1   reg., GHR repair (clear) request
//  BranchCount_o       out  CNT_W  resolved branch/jump count
//  MispredictCount_o   out  CNT_W  mispredict count
// BEHAVIOUR
//  - Pipeline D and E regs each hold {valid, pc, pred_taken, pred_target, btb_hit, pht_idx}.
//  - D: flush (FlushD_i | Mispredict_o) clears valid; else !StallD_i captures F fields, valid=1.
//    Flush beats stall. E: FlushE_i | Mispredict_o clears valid; else captures D each cycle.
//  - Reset (async, any time incl. mid-resolution): all valids, strobes, GHRreset_o, counters = 0;
//    all data regs = 0; Mispredict_o therefore 0, PCredirect_o = 0.
//  - E decode: is_br = op_e==instr_branch_op; is_j = jal|jalr; is_cf = is_br|is_j; all gated by E valid.
//  - Mispredict_o = validE & ( (is_cf & taken_e_i != pred_taken)
//      | (is_cf & taken_e_i & pred_taken & target_e_i != pred_target)
//      | (!is_cf & pred_taken) ).  Last term = BTB alias on non-CF instruction.
//  - PCredirect_o = (is_cf & taken_e_i) ? target_e_i : pcE + 4 (32-bit wrap).
//  - Registered updates, 1-cycle latency after E (asserted for exactly one cycle per E instr):
//    BTB_we_o = is_cf & taken_e_i & (!btb_hit | target_e_i != pred_target);
//    BTBwriteaddress_o = pcE[log2(N)+1:2]; BTBwritedata_o = target_e_i.
//    PHTwe_o = is_br; PHTincrement_o = taken_e_i; PHTwriteaddress_o = pht_idx of E.
//    GHRreset_o = is_br & Mispredict_o.
//    Strobe regs return to 0 the cycle after; data regs hold last value.
//  - Counters: BranchCount += is_cf; MispredictCount += Mispredict_o; both saturate at
//    all-ones (no wrap). cnt_clr_i clears; clr wins over a same-cycle increment.
//  - Same-cycle mispredict and StallD_i: D still flushed. Back-to-back branches each update.
// TESTING
//  1. Reset low mid-run with E holding a mispredicting beq -> all outputs 0 immediately, counters 0.
//  2. beq at pc 0x40, pred not-taken, taken_e_i=1, target 0x80 -> Mispredict_o=1, PCredirect_o=0x80;
//     next cycle BTB_we_o=1 addr=16 data=0x80, PHTwe_o=1 inc=1, GHRreset_o=1.
//  3. beq pc 0x44 pred taken, btb_hit, target 0x90, actual not taken -> redirect 0x48, BTB_we_o=0, PHT inc=0.
//  4. jal pc 0x10 pred hit target 0x100, actual 0x100 -> Mispredict_o=0, BTB_we_o=0, PHTwe_o=0, BranchCount+1.
//  5. addi pc 0x20 with pred_taken=1 (alias) -> Mispredict_o=1, PCredirect_o=0x24, no BTB/PHT write.
//  6. CNT_W=4: 20 mispredicts -> MispredictCount_o=15 held; cnt_clr_i with mispredict -> 0; StallD_i+FlushD_i -> D valid 0.

Source files
------------

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-side branch resolution: carries fetch predictions through D and E, detects
// mispredicts in E, and issues registered BTB/PHT/GHR update strobes plus perf counters.
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int CNT_W           = 16
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [31:0]                        pc_f_i,
    input  logic                               BranchTaken_f_i,
    input  logic [31:0]                        BTBtarget_f_i,
    input  logic                               BTBhit_f_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddress_f_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               FlushE_i,
    input  logic [6:0]                         op_e_i,
    input  logic                               taken_e_i,
    input  logic [31:0]                        target_e_i,
    input  logic                               cnt_clr_i,
    output logic                               Mispredict_o,
    output logic [31:0]                        PCredirect_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
    output logic [CNT_W-1:0]                   BranchCount_o,
    output logic [CNT_W-1:0]                   MispredictCount_o
);

    localparam int              BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
    localparam logic [6:0]      OP_JAL    = 7'b1101111;
    localparam logic [6:0]      OP_JALR   = 7'b1100111;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    r_valid_d, r_pred_taken_d, r_btb_hit_d;
    logic [31:0]             r_pc_d, r_pred_target_d;
    logic [NUM_GHR_BITS-1:0] r_pht_idx_d;

    logic                    r_valid_e, r_pred_taken_e, r_btb_hit_e;
    logic [31:0]             r_pc_e, r_pred_target_e;
    logic [NUM_GHR_BITS-1:0] r_pht_idx_e;

    logic                    r_btb_we, r_pht_we, r_pht_inc, r_ghr_reset;
    logic [BTB_IDX_W-1:0]    r_btb_waddr;
    logic [31:0]             r_btb_wdata;
    logic [NUM_GHR_BITS-1:0] r_pht_waddr;
    logic [CNT_W-1:0]        r_br_cnt, r_mp_cnt;

    logic w_is_br, w_is_j, w_is_cf, w_tgt_diff, w_mispredict, w_btb_we;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_valid_d       <= 1'b0;
            r_pc_d          <= '0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
            r_btb_hit_d     <= 1'b0;
            r_pht_idx_d     <= '0;
        end else if (FlushD_i | w_mispredict) begin
            r_valid_d <= 1'b0;
        end else if (!StallD_i) begin
            r_valid_d       <= 1'b1;
            r_pc_d          <= pc_f_i;
            r_pred_taken_d  <= BranchTaken_f_i;
            r_pred_target_d <= BTBtarget_f_i;
            r_btb_hit_d     <= BTBhit_f_i;
            r_pht_idx_d     <= PHTreadaddress_f_i;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_valid_e       <= 1'b0;
            r_pc_e          <= '0;
            r_pred_taken_e  <= 1'b0;
            r_pred_target_e <= '0;
            r_btb_hit_e     <= 1'b0;
            r_pht_idx_e     <= '0;
        end else if (FlushE_i | w_mispredict) begin
            r_valid_e <= 1'b0;
        end else begin
            r_valid_e       <= r_valid_d;
            r_pc_e          <= r_pc_d;
            r_pred_taken_e  <= r_pred_taken_d;
            r_pred_target_e <= r_pred_target_d;
            r_btb_hit_e     <= r_btb_hit_d;
            r_pht_idx_e     <= r_pht_idx_d;
        end
    end

    assign w_is_br    = r_valid_e & (op_e_i == OP_BRANCH);
    assign w_is_j     = r_valid_e & ((op_e_i == OP_JAL) | (op_e_i == OP_JALR));
    assign w_is_cf    = w_is_br | w_is_j;
    assign w_tgt_diff = (target_e_i != r_pred_target_e);

    // A predicted-taken non-control-flow instruction means the BTB aliased onto it.
    assign w_mispredict = r_valid_e & (
                              (w_is_cf & (taken_e_i != r_pred_taken_e))
                            | (w_is_cf & taken_e_i & r_pred_taken_e & w_tgt_diff)
                            | (~w_is_cf & r_pred_taken_e));

    assign w_btb_we = w_is_cf & taken_e_i & (~r_btb_hit_e | w_tgt_diff);

    assign Mispredict_o = w_mispredict;
    assign PCredirect_o = !r_valid_e ? 32'd0 :
                          (w_is_cf & taken_e_i) ? target_e_i : (r_pc_e + 32'd4);

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_btb_we    <= 1'b0;
            r_btb_waddr <= '0;
            r_btb_wdata <= '0;
            r_pht_we    <= 1'b0;
            r_pht_inc   <= 1'b0;
            r_pht_waddr <= '0;
            r_ghr_reset <= 1'b0;
        end else begin
            r_btb_we    <= w_btb_we;
            r_pht_we    <= w_is_br;
            r_ghr_reset <= w_is_br & w_mispredict;
            if (w_btb_we) begin
                r_btb_waddr <= r_pc_e[BTB_IDX_W+1:2];
                r_btb_wdata <= target_e_i;
            end
            if (w_is_br) begin
                r_pht_inc   <= taken_e_i;
                r_pht_waddr <= r_pht_idx_e;
            end
        end
    end

    // Counters saturate rather than wrap; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else begin
            if (w_is_cf && (r_br_cnt != CNT_MAX)) r_br_cnt <= r_br_cnt + CNT_ONE;
            if (w_mispredict && (r_mp_cnt != CNT_MAX)) r_mp_cnt <= r_mp_cnt + CNT_ONE;
        end
    end

    assign BTB_we_o          = r_btb_we;
    assign BTBwriteaddress_o = r_btb_waddr;
    assign BTBwritedata_o    = r_btb_wdata;
    assign PHTwe_o           = r_pht_we;
    assign PHTincrement_o    = r_pht_inc;
    assign PHTwriteaddress_o = r_pht_waddr;
    assign GHRreset_o        = r_ghr_reset;
    assign BranchCount_o     = r_br_cnt;
    assign MispredictCount_o = r_mp_cnt;

endmodule
